// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator with a built-in test-pattern
// colour source.
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   mode         pattern select (0 solid, 1 checker, 2 bars, 3 scrolling bars),
//                latched only at the start of each frame
//   color_in     solid colour {R[2:0],G[2:0],B[1:0]} for mode 0
//   hsync, vsync sync pulses, active level set by HS_POL / VS_POL
//   de           high while the pixel is inside the visible area
//   x, y         current horizontal / vertical count
//   frame_start  one-clk pulse on the first clk showing (0,0)
//   vga_red/green/blue  3/3/2-bit colour, zero outside the visible area
//   frame_cnt    frames since reset, wraps at 256
//
// All outputs are registered from the current divider/counter state, so
// they lag the internal counters by one clk.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CNT_W   = 11,
  parameter int CHK_SH  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [7:0]       color_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic [2:0]       vga_red,
  output logic [2:0]       vga_green,
  output logic [1:0]       vga_blue,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SS  = H_VIS + H_FP;
  localparam int H_SE  = H_SS + H_SYNC;
  localparam int V_SS  = V_VIS + V_FP;
  localparam int V_SE  = V_SS + V_SYNC;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_L = (HS_POL != 0);
  localparam logic VS_L = (VS_POL != 0);

  // Expand a 3-bit bar index into an 8-bit colour, one bit per channel.
  function automatic logic [7:0] bars(input logic [2:0] b);
    return {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             first_q, first_d;

  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       rgb_q, rgb_d;

  logic             pix_en, start, hs_act, vs_act;
  logic [7:0]       pix;

  // Counter state and frame bookkeeping.
  always_comb begin
    pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      if (h_q == CNT_W'(H_TOT - 1)) begin
        h_d = '0;
        v_d = (v_q == CNT_W'(V_TOT - 1)) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end

    // The frame-start clk latches the mode and counts the frame; the very
    // first frame after reset is frame 0, so it only clears first_q.
    start       = (h_q == '0) && (v_q == '0) && (div_q == '0);
    mode_d      = start ? mode : mode_q;
    first_d     = start ? 1'b0 : first_q;
    frame_cnt_d = (start && !first_q) ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  // Registered outputs computed from the current state.
  always_comb begin
    hs_act        = (h_q >= CNT_W'(H_SS)) && (h_q < CNT_W'(H_SE));
    vs_act        = (v_q >= CNT_W'(V_SS)) && (v_q < CNT_W'(V_SE));
    hsync_d       = hs_act ? HS_L : ~HS_L;
    vsync_d       = vs_act ? VS_L : ~VS_L;
    de_d          = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
    x_d           = h_q;
    y_d           = v_q;
    frame_start_d = start;

    // mode_d rather than mode_q so the first pixel of a frame already uses
    // the newly latched mode; frame_cnt_d keeps the scroll offset in step
    // with the frame_cnt output of the same clk.
    case (mode_d)
      2'd0:    pix = color_in;
      2'd1:    pix = (h_q[CHK_SH] ^ v_q[CHK_SH]) ? 8'hFF : 8'h00;
      2'd2:    pix = bars(h_q[9:7]);
      default: pix = bars(3'((h_q + CNT_W'({frame_cnt_d, 1'b0})) >> 7));
    endcase
    rgb_d = de_d ? pix : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      mode_q        <= 2'd0;
      frame_cnt_q   <= 8'd0;
      first_q       <= 1'b1;
      hsync_q       <= ~HS_L;
      vsync_q       <= ~VS_L;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= 8'h00;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      first_q       <= first_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign vga_red     = rgb_q[7:5];
  assign vga_green   = rgb_q[4:2];
  assign vga_blue    = rgb_q[1:0];
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with a built-in test-pattern colour source. It is the successor to the fixed 640x480@60 controller.
- Timing geometry, sync polarity and pixel-clock divide ratio are set by parameters.
- It produces registered sync, data-enable, pixel coordinates, frame strobe and 8-bit RGB (3/3/2).
- It sits between the system clock and the VGA connector and provides x/y to downstream pixel sources.

Parameters:
- CLK_DIV, 4: system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hsync active level (0 = active low).
- VS_POL, 0: vsync active level (0 = active low).
- CNT_W, 11: width of the h/v counters and of the x/y ports.
- CHK_SH, 6: checker square size is 2^CHK_SH pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  pattern select: 0 solid, 1 checker, 2 bars, 3 scrolling bars.
- color_in  in  8  solid colour, {R[2:0],G[2:0],B[1:0]}.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- de  out  1  high while the pixel is in the visible area.
- x  out  CNT_W  current horizontal count.
- y  out  CNT_W  current vertical count.
- frame_start  out  1  one-clk pulse at the first clk showing (0,0).
- vga_red  out  3  red.
- vga_green  out  3  green.
- vga_blue  out  2  blue.
- frame_cnt  out  8  frames since reset, wraps.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT = V_VIS+V_FP+V_SYNC+V_BP. Line order is visible, front porch, sync, back porch, both horizontally and vertically.
- Divider: div_cnt runs 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1.
- Counters: h_cnt and v_cnt advance only on pix_en.
  - h_cnt wraps from H_TOT-1 to 0.
  - v_cnt increments only when h_cnt wraps, and wraps from V_TOT-1 to 0.
  - Each (h,v) position is held for exactly CLK_DIV clks.
- Outputs are registered every clk from the current div/h/v state, so they lag the counters by one clk.
  - hsync = HS_POL when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, else ~HS_POL.
  - vsync: same rule on v_cnt using the V_* parameters and VS_POL.
  - de = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - x = h_cnt, y = v_cnt.
  - frame_start = (h_cnt==0 && v_cnt==0 && div_cnt==0).
- Mode latch: mode_q samples mode only in the clk where frame_start is being generated. A mode change mid-frame takes effect at the next frame; there is no tearing.
- frame_cnt increments by 1 (mod 256) on the same condition, except the first frame after reset, which reads 0.
- Colour (8-bit, registered alongside the sync outputs); all zero when de = 0:
  - mode 0: color_in, sampled every clk.
  - mode 1: 8'hFF if x[CHK_SH]^y[CHK_SH], else 8'h00.
  - mode 2: b = x[9:7]; colour = {b[2],b[2],b[2], b[1],b[1],b[1], b[0],b[0]}.
  - mode 3: same as mode 2 with b = (x + {frame_cnt,1'b0})[9:7], truncated to CNT_W.
- Reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - de, x, y, RGB, frame_start, frame_cnt = 0.
  - Internal counters = 0; mode_q = 0.
- First clk after rst falls: outputs show (0,0) with frame_start = 1, and mode is latched.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). The raster restarts at (0,0) on release.
- Boundaries:
  - h_cnt == H_TOT-1 with pix_en: h wraps and v advances in the same clk.
  - Last pixel of the frame: both counters wrap to 0 together.

Test Plan:
- Reset, then release with defaults → first output clk: x=0, y=0, frame_start=1, de=1, hsync=1, vsync=1. The next frame_start arrives exactly 800*525*4 = 1,680,000 clks later.
- Line timing (defaults) → hsync low for exactly 384 clks, starting when x becomes 656; de high for 2560 clks per visible line; line period 3200 clks.
- Frame timing → vsync low for exactly 2 lines (6400 clks) while y = 490..491; de never high for y >= 480; frame_cnt increments by 1 per frame and wraps 255→0.
- Mode change: mode=0, color_in=8'hA5, switch to mode=1 at y=100 → remainder of the frame stays 8'hA5. The next frame shows the checker: (0,0)=00, (64,0)=FF, (64,64)=00.
- CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1 → line period 14 clks; hsync high for 2 clks at x=10..11; frame period 98 clks; de high 32 clks per frame.
- Assert rst asynchronously at x=300, y=200 → outputs reach reset values without waiting for a clk edge. After release, frame_start=1 at (0,0) and frame_cnt=0.
